// File: rtl/pad_cell_input_filter_pkg.sv
// rtl/pad_cell_input_filter_pkg.sv - pad attribute field layout and filter threshold helper
package pad_cell_input_filter_pkg;

  localparam int unsigned PAD_ATTR_FILT_EN_BIT  = 0;
  localparam int unsigned PAD_ATTR_FILT_THR_LSB = 8;
  localparam int unsigned PAD_ATTR_FILT_THR_W   = 8;

  typedef logic [PAD_ATTR_FILT_THR_W-1:0] pad_filt_thr_t;

  // A disabled filter or a zero threshold both collapse to a one-cycle qualify.
  function automatic pad_filt_thr_t eff_threshold(input logic en, input pad_filt_thr_t thr);
    return (!en || thr == '0) ? pad_filt_thr_t'(1) : thr;
  endfunction

endpackage

// File: rtl/pad_cell_input_filter_sync_chain.sv
// rtl/pad_cell_input_filter_sync_chain.sv - pad_sync_chain: N-flop synchronizer with reset value
module pad_sync_chain #(
  parameter int unsigned N           = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic sync_level
);

  logic [N-1:0] stages;

  // Straight flop-to-flop chain: nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {N{RESET_VALUE}};
    end else begin
      stages <= {stages[N-2:0], level};
    end
  end

  assign sync_level = stages[N-1];

endmodule

// File: rtl/pad_cell_input_filter.sv
// rtl/pad_cell_input_filter.sv - synchronize a pad level, glitch-filter it and emit rise/fall pulses
module pad_cell_input_filter
  import pad_cell_input_filter_pkg::*;
#(
  parameter int unsigned PADATTR     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  inout  wire                pad_io,
  input  logic [PADATTR-1:0] pad_attributes_i,
  output logic               pad_out_o,
  output logic               rise_o,
  output logic               fall_o
);

  logic          sync_s;
  logic          out_q, out_d, out_n;
  pad_filt_thr_t cnt_q, cnt_n;
  pad_filt_thr_t thr, teff;
  logic          filt_en;
  logic [8:0]    cnt_inc;
  logic          unused_attr;

  assign pad_io = 1'bz;

  pad_sync_chain #(
    .N           (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .level      (pad_io),
    .sync_level (sync_s)
  );

  assign filt_en     = pad_attributes_i[PAD_ATTR_FILT_EN_BIT];
  assign thr         = pad_attributes_i[PAD_ATTR_FILT_THR_LSB +: PAD_ATTR_FILT_THR_W];
  assign teff        = eff_threshold(filt_en, thr);
  assign unused_attr = ^pad_attributes_i[7:1] ^ ^(pad_attributes_i >> 16);

  // Widened increment so the >= compare also covers a threshold lowered mid-count.
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    out_n = out_q;
    cnt_n = cnt_q;
    if (sync_s == out_q) begin
      cnt_n = '0;
    end else if (cnt_inc >= {1'b0, teff}) begin
      out_n = sync_s;
      cnt_n = '0;
    end else begin
      cnt_n = cnt_inc[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= RESET_VALUE;
      out_d <= RESET_VALUE;
      cnt_q <= '0;
    end else begin
      out_q <= out_n;
      out_d <= out_q;
      cnt_q <= cnt_n;
    end
  end

  assign pad_out_o = out_q;
  assign rise_o    = out_q & ~out_d;
  assign fall_o    = ~out_q & out_d;

endmodule
